// File: rtl/regfile_pkg.sv
// Shared types and default widths for the multi-read-port register file.
package regfile_pkg;

   typedef enum logic {RF_CLEAR, RF_READY} rf_state_t;

   localparam int RF_ADDR_W = 5;
   localparam int RF_DATA_W = 32;

endpackage

// File: rtl/regfile_mp_if.sv
// Register file bus: one write port, NUM_RD read ports, clear request and ready.
interface regfile_mp_if
   import regfile_pkg::*;
#(
   parameter int ADDR_WIDTH = RF_ADDR_W,
   parameter int DATA_WIDTH = RF_DATA_W,
   parameter int NUM_RD     = 2
) ();

   logic                                 clr;
   logic                                 we;
   logic [ADDR_WIDTH-1:0]                write_addr;
   logic [DATA_WIDTH-1:0]                din;
   logic [NUM_RD-1:0][ADDR_WIDTH-1:0]    read_addr;
   logic [NUM_RD-1:0][DATA_WIDTH-1:0]    dout;
   logic                                 ready;

   modport master (
      output clr, we, write_addr, din, read_addr,
      input  dout, ready
   );

   modport slave (
      input  clr, we, write_addr, din, read_addr,
      output dout, ready
   );

endinterface

// File: rtl/regfile_rdport.sv
// One registered read port: zero/out-of-range masking, write-through bypass, output flop.
module regfile_rdport
   import regfile_pkg::*;
#(
   parameter int ADDR_WIDTH = RF_ADDR_W,
   parameter int DATA_WIDTH = RF_DATA_W,
   parameter int RAM_SIZE   = 32,
   parameter int ZERO_REG   = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rd_en_i,
   input  logic [ADDR_WIDTH-1:0] rd_addr_i,
   input  logic                  wr_fire_i,
   input  logic [ADDR_WIDTH-1:0] wr_addr_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic [DATA_WIDTH-1:0] ram_data_i,
   output logic [DATA_WIDTH-1:0] dout_o
);

   logic [DATA_WIDTH-1:0] dout_d;
   logic [DATA_WIDTH-1:0] dout_q;
   logic                  masked;

   assign masked = ((ZERO_REG != 0) && (rd_addr_i == '0)) ||
                   (32'(rd_addr_i) >= RAM_SIZE);

   always_comb begin
      dout_d = ram_data_i;
      if (!rd_en_i || masked) begin
         dout_d = '0;
      end else if (wr_fire_i && (wr_addr_i == rd_addr_i)) begin
         dout_d = wr_data_i;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout_q <= '0;
      end else begin
         dout_q <= dout_d;
      end
   end

   assign dout_o = dout_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with a clear sequencer that zeroes the array
// after reset or on request, leaving the storage itself without a reset net.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int ADDR_WIDTH = RF_ADDR_W,
   parameter int DATA_WIDTH = RF_DATA_W,
   parameter int RAM_SIZE   = 32,
   parameter int NUM_RD     = 2,
   parameter int ZERO_REG   = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   regfile_mp_if.slave  bus
);

   localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(RAM_SIZE - 1);

   rf_state_t                          state_q, state_d;
   logic [ADDR_WIDTH-1:0]              clr_idx_q, clr_idx_d;
   logic                               ready_q;
   logic [DATA_WIDTH-1:0]              ram_q [RAM_SIZE];
   logic                               wr_ok;
   logic                               wr_fire;
   logic                               ram_we;
   logic [ADDR_WIDTH-1:0]              ram_waddr;
   logic [DATA_WIDTH-1:0]              ram_wdata;
   logic [NUM_RD-1:0][DATA_WIDTH-1:0]  dout_q;

   always_comb begin
      state_d   = state_q;
      clr_idx_d = clr_idx_q;
      if (bus.clr) begin
         state_d   = RF_CLEAR;
         clr_idx_d = '0;
      end else if (state_q == RF_CLEAR) begin
         if (clr_idx_q == LAST_IDX) begin
            state_d   = RF_READY;
            clr_idx_d = '0;
         end else begin
            clr_idx_d = clr_idx_q + ADDR_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= RF_CLEAR;
         clr_idx_q <= '0;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         clr_idx_q <= clr_idx_d;
         ready_q   <= (state_d == RF_READY);
      end
   end

   // A user write lands only in RF_READY, never together with clr, and never
   // on the hardwired-zero entry or past the end of the array.
   assign wr_ok   = !((ZERO_REG != 0) && (bus.write_addr == '0)) &&
                    (32'(bus.write_addr) < RAM_SIZE);
   assign wr_fire = (state_q == RF_READY) && bus.we && !bus.clr && wr_ok;

   always_comb begin
      ram_we    = wr_fire;
      ram_waddr = bus.write_addr;
      ram_wdata = bus.din;
      if (state_q == RF_CLEAR) begin
         ram_we    = 1'b1;
         ram_waddr = clr_idx_q;
         ram_wdata = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (ram_we) begin
         ram_q[ram_waddr] <= ram_wdata;
      end
   end

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [DATA_WIDTH-1:0] ram_rd;

      assign ram_rd = (32'(bus.read_addr[i]) < RAM_SIZE) ? ram_q[bus.read_addr[i]] : '0;

      regfile_rdport #(
         .ADDR_WIDTH (ADDR_WIDTH),
         .DATA_WIDTH (DATA_WIDTH),
         .RAM_SIZE   (RAM_SIZE),
         .ZERO_REG   (ZERO_REG)
      ) u_rdport (
         .clk        (clk),
         .rst_n      (rst_n),
         .rd_en_i    (state_q == RF_READY),
         .rd_addr_i  (bus.read_addr[i]),
         .wr_fire_i  (wr_fire),
         .wr_addr_i  (bus.write_addr),
         .wr_data_i  (bus.din),
         .ram_data_i (ram_rd),
         .dout_o     (dout_q[i])
      );
   end

   assign bus.dout  = dout_q;
   assign bus.ready = ready_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed vector table, clear/reset sequences and a
// randomized run against an array-based reference model.
module tb_regfile_mp;

   localparam int AW = 5;
   localparam int DW = 32;
   localparam int NR = 2;
   localparam int RS = 32;

   logic clk;
   logic rst_n;

   regfile_mp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR)) bus ();

   regfile_mp #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW),
      .RAM_SIZE   (RS),
      .NUM_RD     (NR),
      .ZERO_REG   (1)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests_run;
   int tests_failed;

   // Reference model: contents as the spec defines them, plus edges left in a clear.
   logic [DW-1:0] mdl_mem [RS];
   int            mdl_clear_left;
   logic [DW-1:0] exp_d [NR];
   logic          exp_rdy;

   typedef struct {
      string         name;
      logic          clr;
      logic          we;
      int            wa;
      logic [DW-1:0] din;
      int            ra0;
      int            ra1;
      logic [DW-1:0] exp0;
      logic [DW-1:0] exp1;
      logic          exp_rdy;
   } vec_t;

   vec_t vecs [10];

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < RS; i++) mdl_mem[i] = '0;
      mdl_clear_left = RS;
      for (int p = 0; p < NR; p++) exp_d[p] = '0;
      exp_rdy = 1'b0;
   endtask

   task automatic model_edge(input logic clr, input logic we, input int wa,
                             input logic [DW-1:0] din, input int ra [NR]);
      bit wr_valid;
      wr_valid = we && !clr && (wa != 0) && (wa < RS);
      if (mdl_clear_left > 0) begin
         for (int p = 0; p < NR; p++) exp_d[p] = '0;
         mdl_clear_left = clr ? RS : mdl_clear_left - 1;
      end else begin
         for (int p = 0; p < NR; p++) begin
            if (ra[p] == 0 || ra[p] >= RS) exp_d[p] = '0;
            else if (wr_valid && wa == ra[p]) exp_d[p] = din;
            else exp_d[p] = mdl_mem[ra[p]];
         end
         if (clr) begin
            for (int i = 0; i < RS; i++) mdl_mem[i] = '0;
            mdl_clear_left = RS;
         end else if (wr_valid) begin
            mdl_mem[wa] = din;
         end
      end
      exp_rdy = (mdl_clear_left == 0);
   endtask

   // Drive one cycle of inputs, let the edge happen, sample 1 time unit later.
   task automatic cycle(input logic clr, input logic we, input int wa,
                        input logic [DW-1:0] din, input int ra0, input int ra1);
      int ra [NR];
      ra[0] = ra0;
      ra[1] = ra1;
      bus.clr          = clr;
      bus.we           = we;
      bus.write_addr   = AW'(wa);
      bus.din          = din;
      bus.read_addr[0] = AW'(ra0);
      bus.read_addr[1] = AW'(ra1);
      @(posedge clk);
      model_edge(clr, we, wa, din, ra);
      #1;
   endtask

   task automatic idle();
      cycle(1'b0, 1'b0, 0, '0, 0, 0);
   endtask

   task automatic count_to_ready(input string name);
      int n;
      n = 0;
      for (int i = 1; i <= 40; i++) begin
         idle();
         if (bus.ready === 1'b1) begin
            n = i;
            break;
         end
      end
      chk(name, DW'(n), DW'(RS));
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      bus.clr        = 1'b0;
      bus.we         = 1'b0;
      bus.write_addr = '0;
      bus.din        = '0;
      bus.read_addr  = '0;
      rst_n          = 1'b0;
      model_reset();

      vecs[0] = '{"wr_r5",        0, 1, 5, 32'hDEADBEEF, 0, 0, 32'h0,        32'h0,        1};
      vecs[1] = '{"rd_r5",        0, 0, 0, 32'h0,        5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 1};
      vecs[2] = '{"wr_r7",        0, 1, 7, 32'h11111111, 5, 5, 32'hDEADBEEF, 32'hDEADBEEF, 1};
      vecs[3] = '{"wr_r8",        0, 1, 8, 32'h33333333, 7, 0, 32'h11111111, 32'h0,        1};
      vecs[4] = '{"bypass_r7",    0, 1, 7, 32'h22222222, 7, 8, 32'h22222222, 32'h33333333, 1};
      vecs[5] = '{"rd_r7_new",    0, 0, 0, 32'h0,        7, 7, 32'h22222222, 32'h22222222, 1};
      vecs[6] = '{"wr_r0",        0, 1, 0, 32'hFFFFFFFF, 0, 0, 32'h0,        32'h0,        1};
      vecs[7] = '{"rd_r0_later",  0, 0, 0, 32'h0,        0, 5, 32'h0,        32'hDEADBEEF, 1};
      vecs[8] = '{"bypass_both",  0, 1, 9, 32'hA5A5A5A5, 9, 9, 32'hA5A5A5A5, 32'hA5A5A5A5, 1};
      vecs[9] = '{"no_we_no_byp", 0, 0, 9, 32'h5A5A5A5A, 9, 1, 32'hA5A5A5A5, 32'h0,        1};

      #3;
      chk("rst_ready", DW'(bus.ready), '0);
      chk("rst_dout0", bus.dout[0], '0);
      chk("rst_dout1", bus.dout[1], '0);
      #4;
      rst_n = 1'b1;

      // Power-up clear with read_addr held at 3.
      for (int i = 1; i <= RS; i++) begin
         cycle(1'b0, 1'b0, 0, '0, 3, 3);
         chk($sformatf("pwrup_ready_e%0d", i), DW'(bus.ready), DW'(i == RS));
         chk($sformatf("pwrup_dout0_e%0d", i), bus.dout[0], '0);
      end
      for (int i = 0; i < RS; i += 2) begin
         cycle(1'b0, 1'b0, 0, '0, i, i + 1);
         chk("pwrup_zero0", bus.dout[0], '0);
         chk("pwrup_zero1", bus.dout[1], '0);
      end

      foreach (vecs[k]) begin
         cycle(vecs[k].clr, vecs[k].we, vecs[k].wa, vecs[k].din, vecs[k].ra0, vecs[k].ra1);
         chk({vecs[k].name, "_p0"}, bus.dout[0], vecs[k].exp0);
         chk({vecs[k].name, "_p1"}, bus.dout[1], vecs[k].exp1);
         chk({vecs[k].name, "_rdy"}, DW'(bus.ready), DW'(vecs[k].exp_rdy));
      end

      // Mid-operation clear colliding with a write.
      for (int i = 1; i < RS; i++) cycle(1'b0, 1'b1, i, DW'(i), 0, 0);
      cycle(1'b1, 1'b1, 2, 32'hAA, 2, 3);
      chk("clr_rd_old_r2", bus.dout[0], 32'd2);
      chk("clr_ready_low", DW'(bus.ready), '0);
      count_to_ready("clr_duration");
      for (int i = 0; i < RS; i += 2) begin
         cycle(1'b0, 1'b0, 0, '0, i, i + 1);
         chk($sformatf("clr_zero_r%0d", i), bus.dout[0], '0);
         chk($sformatf("clr_zero_r%0d", i + 1), bus.dout[1], '0);
      end

      // Randomized traffic against the model.
      for (int n = 0; n < 600; n++) begin
         logic c, w;
         int   wa, r0, r1;
         c  = ($urandom_range(0, 79) == 0);
         w  = $urandom_range(0, 1);
         wa = $urandom_range(0, RS - 1);
         r0 = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, RS - 1);
         r1 = ($urandom_range(0, 3) == 0) ? wa : $urandom_range(0, RS - 1);
         cycle(c, w, wa, $urandom, r0, r1);
         chk("rnd_p0", bus.dout[0], exp_d[0]);
         chk("rnd_p1", bus.dout[1], exp_d[1]);
         chk("rnd_rdy", DW'(bus.ready), DW'(exp_rdy));
      end

      // Reset in the middle of operation with a non-zero value on dout.
      for (int i = 0; i < 40 && bus.ready !== 1'b1; i++) idle();
      cycle(1'b0, 1'b1, 4, 32'h12345678, 0, 0);
      cycle(1'b0, 1'b0, 0, '0, 4, 4);
      chk("pre_rst_dout0", bus.dout[0], 32'h12345678);
      #1;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("midop_rst_dout0", bus.dout[0], '0);
      chk("midop_rst_ready", DW'(bus.ready), '0);
      #1;
      rst_n = 1'b1;
      count_to_ready("midop_rst_len");

      // Reset while the clear sequencer is at index 10.
      cycle(1'b1, 1'b0, 0, '0, 0, 0);
      for (int i = 0; i < 10; i++) idle();
      #1;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("midclr_rst_dout1", bus.dout[1], '0);
      chk("midclr_rst_ready", DW'(bus.ready), '0);
      #1;
      rst_n = 1'b1;
      count_to_ready("midclr_rst_len");
      cycle(1'b0, 1'b0, 0, '0, 4, 9);
      chk("post_rst_r4", bus.dout[0], '0);
      chk("post_rst_r9", bus.dout[1], '0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
